// File: rtl/ysyx_210238_pipe_ctrl.sv
// Pipeline control: turns hazard-detector indications into per-stage stall/flush
// controls, sequencing multi-cycle load-use bubbles and redirects deferred by a busy fetch.
module ysyx_210238_pipe_ctrl #(
  parameter int PC_W            = 64,
  parameter int DATA_LU_BUBBLES = 1,
  parameter int BR_LU_BUBBLES   = 2,
  parameter int CNT_W           = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_use,
  input  logic              i_ctrl_load_use,
  input  logic              i_branch_taken,
  input  logic [PC_W-1:0]   i_branch_target,
  input  logic              i_if_busy,
  input  logic              i_ls_busy,
  output logic              o_pc_stall,
  output logic              o_if_id_stall,
  output logic              o_if_id_flush,
  output logic              o_id_ex_stall,
  output logic              o_id_ex_flush,
  output logic              o_ex_ls_stall,
  output logic              o_redirect_valid,
  output logic [PC_W-1:0]   o_redirect_pc,
  output logic [CNT_W-1:0]  o_stall_cycles
);

  typedef enum logic [1:0] {RUN, LU_WAIT, RDR_WAIT} state_t;

  localparam logic [1:0] DATA_INIT = 2'(DATA_LU_BUBBLES - 1);
  localparam logic [1:0] BR_INIT   = 2'(BR_LU_BUBBLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_bub;
  logic [1:0]         w_bub_nxt;
  logic [PC_W-1:0]    r_tgt;
  logic [PC_W-1:0]    w_tgt_nxt;
  logic [CNT_W-1:0]   r_stall_cnt;

  always_comb begin
    o_pc_stall       = 1'b0;
    o_if_id_stall    = 1'b0;
    o_if_id_flush    = 1'b0;
    o_id_ex_stall    = 1'b0;
    o_id_ex_flush    = 1'b0;
    o_ex_ls_stall    = 1'b0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    w_state_nxt      = r_state;
    w_bub_nxt        = r_bub;
    w_tgt_nxt        = r_tgt;
    if (!i_rst_n) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
      w_state_nxt   = RUN;
      w_bub_nxt     = '0;
      w_tgt_nxt     = '0;
    end else if (i_ls_busy) begin
      // Memory stall freezes the whole pipe; all sequencing state holds.
      o_pc_stall    = 1'b1;
      o_if_id_stall = 1'b1;
      o_id_ex_stall = 1'b1;
      o_ex_ls_stall = 1'b1;
    end else begin
      unique case (r_state)
        RUN: begin
          if (i_ctrl_load_use || i_load_use) begin
            o_pc_stall    = 1'b1;
            o_if_id_stall = 1'b1;
            o_id_ex_flush = 1'b1;
            w_bub_nxt     = i_ctrl_load_use ? BR_INIT : DATA_INIT;
            w_state_nxt   = (w_bub_nxt != 2'd0) ? LU_WAIT : RUN;
          end else if (i_branch_taken && !i_if_busy) begin
            o_redirect_valid = 1'b1;
            o_redirect_pc    = i_branch_target;
            o_if_id_flush    = 1'b1;
          end else if (i_branch_taken) begin
            o_pc_stall    = 1'b1;
            o_if_id_flush = 1'b1;
            w_tgt_nxt     = i_branch_target;
            w_state_nxt   = RDR_WAIT;
          end else if (i_if_busy) begin
            o_pc_stall    = 1'b1;
            o_if_id_flush = 1'b1;
          end
        end
        LU_WAIT: begin
          o_pc_stall    = 1'b1;
          o_if_id_stall = 1'b1;
          o_id_ex_flush = 1'b1;
          w_bub_nxt     = r_bub - 2'd1;
          if (r_bub <= 2'd1) begin
            w_state_nxt = RUN;
          end
        end
        RDR_WAIT: begin
          o_if_id_flush = 1'b1;
          if (i_if_busy) begin
            o_pc_stall = 1'b1;
          end else begin
            o_redirect_valid = 1'b1;
            o_redirect_pc    = r_tgt;
            w_state_nxt      = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= RUN;
      r_bub       <= '0;
      r_tgt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bub   <= w_bub_nxt;
      r_tgt   <= w_tgt_nxt;
      if (o_pc_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign o_stall_cycles = r_stall_cnt;

endmodule

// File: doc/ysyx_210238_pipe_ctrl.md
Name: ysyx_210238_pipe_ctrl

Overview:
Pipeline control unit that sits directly downstream of the hazard detect unit. It consumes the load-use, branch load-use, memory-busy, fetch-busy and branch-redirect indications. It produces per-stage stall and flush controls for the PC and the IF/ID, ID/EX and EX/LS pipeline registers. It holds the multi-cycle bubble sequencing and redirect-pending state that the combinational hazard detector cannot.

Parameters:
PC_W, 64, width of PC / redirect target
DATA_LU_BUBBLES, 1, bubbles inserted for a data load-use (1..3)
BR_LU_BUBBLES, 2, bubbles inserted for a branch load-use (1..3)
CNT_W, 32, width of the stall performance counter

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_load_use  input  1  data load-use hazard from hazard detector
i_ctrl_load_use  input  1  branch-in-ID load-use hazard from hazard detector
i_branch_taken  input  1  branch/jump in ID resolved taken
i_branch_target  input  PC_W  redirect target for i_branch_taken
i_if_busy  input  1  instruction fetch outstanding, no valid instruction this cycle
i_ls_busy  input  1  LS-stage memory access outstanding
o_pc_stall  output  1  hold PC
o_if_id_stall  output  1  hold IF/ID register
o_if_id_flush  output  1  load bubble into IF/ID
o_id_ex_stall  output  1  hold ID/EX register
o_id_ex_flush  output  1  load bubble into ID/EX
o_ex_ls_stall  output  1  hold EX/LS register
o_redirect_valid  output  1  PC redirect this cycle
o_redirect_pc  output  PC_W  redirect target
o_stall_cycles  output  CNT_W  saturating count of cycles with o_pc_stall=1

Behaviour:
- Reset state
  - State register: RUN. Bubble counter: 0. Latched target: 0. o_stall_cycles: 0.
  - While i_rst_n=0, outputs are: o_if_id_flush=1, o_id_ex_flush=1, all stalls=0, o_redirect_valid=0, o_redirect_pc=0.
- Output timing: outputs are combinational from current state and inputs. State, counter, target and perf counter update on the i_clk rising edge.
- States: RUN, LU_WAIT, RDR_WAIT.
- Freeze (highest priority, any state)
  - Condition: i_ls_busy=1.
  - o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_ls_stall = 1. All flushes = 0. o_redirect_valid = 0.
  - State, counter and latched target hold. All other inputs are ignored that cycle.
- RUN, when not frozen (conditions in priority order):
  - i_ctrl_load_use: o_pc_stall=1, o_if_id_stall=1, o_id_ex_flush=1, i_branch_taken ignored. Counter <= BR_LU_BUBBLES-1. Go to LU_WAIT if that value is nonzero, else stay in RUN.
  - else i_load_use: same outputs, using DATA_LU_BUBBLES.
  - else i_branch_taken with i_if_busy=0: o_redirect_valid=1, o_redirect_pc=i_branch_target, o_if_id_flush=1. Stay in RUN.
  - else i_branch_taken with i_if_busy=1: o_pc_stall=1, o_if_id_flush=1. Latch i_branch_target. Go to RDR_WAIT.
  - else i_if_busy: o_pc_stall=1, o_if_id_flush=1; downstream stages advance.
  - else: all outputs 0.
- LU_WAIT, when not frozen:
  - Outputs: o_pc_stall=1, o_if_id_stall=1, o_id_ex_flush=1, regardless of the hazard inputs.
  - Counter decrements. When counter=1 this cycle, next state is RUN.
  - i_branch_taken and i_if_busy are ignored.
- RDR_WAIT, when not frozen:
  - While i_if_busy=1: o_pc_stall=1, o_if_id_flush=1.
  - When i_if_busy=0: o_redirect_valid=1, o_redirect_pc=latched target, o_if_id_flush=1. Go to RUN.
  - New i_branch_taken, i_load_use and i_ctrl_load_use are ignored; ID holds a bubble.
- o_stall_cycles increments by 1 in every cycle with o_pc_stall=1 and i_rst_n=1. It saturates at all-ones and never wraps.
- Invariants:
  - o_redirect_valid and o_pc_stall are never both 1.
  - A stage's stall and flush are never both 1.
- Reset mid-operation (LU_WAIT or RDR_WAIT): the latched redirect is discarded and the state returns to RUN on the next edge.

Test Plan:
- Data load-use: i_load_use=1 for 1 cycle with defaults -> exactly 1 cycle of o_pc_stall=1, o_if_id_stall=1, o_id_ex_flush=1; state stays RUN; o_stall_cycles=1.
- Branch load-use: i_ctrl_load_use=1 for 1 cycle then 0, i_branch_taken=1 throughout -> 2 consecutive stall/flush cycles with o_redirect_valid=0; redirect to target 0x8000_0100 occurs on the 3rd cycle.
- Redirect while fetch busy: i_branch_taken=1, target 0x8000_0040, i_if_busy=1 for 3 cycles -> 3 cycles of o_pc_stall=1 and o_if_id_flush=1; o_redirect_valid=1 with o_redirect_pc=0x8000_0040 on the cycle i_if_busy drops.
- Freeze priority: enter LU_WAIT (BR_LU_BUBBLES=3), assert i_ls_busy for 4 cycles mid-sequence -> all four stalls=1, flushes=0, counter holds; the remaining bubbles complete after i_ls_busy drops (total 3 flush cycles).
- Reset mid-RDR_WAIT: drive i_rst_n=0 for 1 cycle -> flushes=1, o_redirect_valid=0, o_stall_cycles=0; next cycle in RUN with i_if_busy=0 gives no redirect.
- Perf counter saturation: with CNT_W=4, hold i_if_busy=1 for 20 cycles -> o_stall_cycles reaches 15 and stays at 15.
